// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encodings,
// flag bit positions and a flag packing helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  localparam int FLG_C = 0;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 3;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic v, input logic c);
    logic [3:0] f;
    f        = '0;
    f[FLG_N] = n;
    f[FLG_Z] = z;
    f[FLG_V] = v;
    f[FLG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/cla_nbit.sv
// WIDTH-bit adder built from 2-bit carry-lookahead groups with the group
// carry rippling between groups; also exposes the carry into the MSB.
module cla_nbit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [WIDTH:0] c;

  assign c[0] = c_i;

  for (genvar gi = 0; gi < WIDTH / 2; gi++) begin : g_grp
    localparam int L = 2 * gi;
    logic g0, p0, g1, p1;

    assign g0 = a_i[L]   & b_i[L];
    assign p0 = a_i[L]   ^ b_i[L];
    assign g1 = a_i[L+1] & b_i[L+1];
    assign p1 = a_i[L+1] ^ b_i[L+1];

    // Group carry-out is formed directly from the group carry-in, not via c[L+1].
    assign c[L+1] = g0 | (p0 & c[L]);
    assign c[L+2] = g1 | (p1 & g0) | (p1 & p0 & c[L]);

    assign sum_o[L]   = p0 ^ c[L];
    assign sum_o[L+1] = p1 ^ c[L+1];
  end

  assign cout_o = c[WIDTH];
  assign cmsb_o = c[WIDTH-1];

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage valid/ready add/subtract pipeline: S1 registers operands, S2
// registers result and {N,Z,V,C}; a carry register chains ADC/SBB beats.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [3:0]       flags
);

  logic             s1_valid_q;
  logic [WIDTH-1:0] a_q, b_q;
  op_e              op_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic [3:0]       flags_q;
  logic             cf_q;

  logic             adv2;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH-1:0] sum_d;
  logic             cout;
  logic             cmsb;
  logic [3:0]       flags_d;

  // S2 frees up when it is empty or being drained this cycle.
  assign adv2     = !out_valid_q || out_ready;
  assign in_ready = rst_n && (!s1_valid_q || adv2);
  assign accept   = in_valid && in_ready;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    b_eff = b_q;
    cin   = 1'b0;
    case (op_q)
      OP_ADD: begin b_eff = b_q;  cin = 1'b0; end
      OP_SUB: begin b_eff = ~b_q; cin = 1'b1; end
      OP_ADC: begin b_eff = b_q;  cin = cf_q; end
      OP_SBB: begin b_eff = ~b_q; cin = cf_q; end
      default: ;
    endcase
  end

  cla_nbit #(.WIDTH(WIDTH)) u_cla (
    .a_i    (a_q),
    .b_i    (b_eff),
    .c_i    (cin),
    .sum_o  (sum_d),
    .cout_o (cout),
    .cmsb_o (cmsb)
  );

  assign flags_d = pack_flags(sum_d[WIDTH-1], (sum_d == '0), cmsb ^ cout, cout);

  // NOTE: operand registers are qualified by s1_valid_q and so carry no reset; only control and visible state are reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op_e'(op);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      flags_q     <= '0;
      cf_q        <= 1'b0;
    end else begin
      if (accept)    s1_valid_q <= 1'b1;
      else if (adv2) s1_valid_q <= 1'b0;

      if (adv2) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s_q     <= sum_d;
          flags_q <= flags_d;
          cf_q    <= cout;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe (WIDTH=8): vector table for isolated and
// streamed beats, plus backpressure and mid-flight reset sequences.
module tb_addsub_pipe;
  import addsub_pkg::*;

  localparam int W  = 8;
  localparam int NV = 13;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic [3:0]   flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic [3:0]   f;   // {N,Z,V,C}
  } vec_t;

  vec_t vecs[NV];
  vec_t bp[5];

  addsub_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic vld);
    op       = v.op;
    a        = v.a;
    b        = v.b;
    in_valid = vld;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Ordered table: ADC/SBB expectations depend on the C of the row above.
    vecs[0]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0101};
    vecs[1]  = '{OP_ADC, 8'h00, 8'h00, 8'h01, 4'b0000};
    vecs[2]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1010};
    vecs[3]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0011};
    vecs[4]  = '{OP_SUB, 8'h01, 8'h02, 8'hFF, 4'b1000};
    vecs[5]  = '{OP_SBB, 8'h00, 8'h00, 8'hFF, 4'b1000};
    vecs[6]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 4'b0101};
    vecs[7]  = '{OP_SBB, 8'h10, 8'h01, 8'h0F, 4'b0001};
    vecs[8]  = '{OP_ADC, 8'h80, 8'h80, 8'h01, 4'b0011};
    vecs[9]  = '{OP_ADD, 8'h3C, 8'hC4, 8'h00, 4'b0101};
    vecs[10] = '{OP_SBB, 8'h00, 8'h00, 8'h00, 4'b0101};
    vecs[11] = '{OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b1000};
    vecs[12] = '{OP_ADC, 8'h12, 8'h34, 8'h46, 4'b0000};

    bp[0] = '{OP_ADD, 8'h10, 8'h01, 8'h11, 4'b0000};
    bp[1] = '{OP_ADD, 8'h20, 8'h02, 8'h22, 4'b0000};
    bp[2] = '{OP_ADD, 8'h30, 8'h03, 8'h33, 4'b0000};
    bp[3] = '{OP_ADD, 8'hF0, 8'h20, 8'h10, 4'b0001};
    bp[4] = '{OP_ADC, 8'h00, 8'h00, 8'h01, 4'b0000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;

    // Reset state while rst_n is held low.
    do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Isolated beats: latency of exactly two cycles, one-cycle output.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i], 1'b1);
      #1;
      check($sformatf("iso%0d_in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("iso%0d_lat1_valid", i), out_valid, 0);
      @(negedge clk);
      check($sformatf("iso%0d_lat2_valid", i), out_valid, 1);
      check($sformatf("iso%0d_s", i), s, vecs[i].s);
      check($sformatf("iso%0d_flags", i), flags, vecs[i].f);
      @(negedge clk);
      check($sformatf("iso%0d_drained", i), out_valid, 0);
    end

    // Back-to-back stream: full throughput and carry chaining between adjacent beats.
    do_reset();
    begin
      int got = 0;
      for (int t = 0; t < NV + 4; t++) begin
        @(negedge clk);
        if (out_valid && got < NV) begin
          check($sformatf("str%0d_s", got), s, vecs[got].s);
          check($sformatf("str%0d_flags", got), flags, vecs[got].f);
          got++;
        end
        if (t < NV) drive(vecs[t], 1'b1);
        else in_valid = 1'b0;
        #1;
        if (t < NV) check($sformatf("str%0d_in_ready", t), in_ready, 1);
      end
      check("str_count", got, NV);
    end

    // Backpressure: out_ready low in cycles 2..6, five beats offered.
    do_reset();
    begin
      int idx = 0;
      int got = 0;
      logic         hold = 1'b0;
      logic [W-1:0] hs = '0;
      logic [3:0]   hf = '0;
      for (int cyc = 0; cyc < 30; cyc++) begin
        @(negedge clk);
        out_ready = !(cyc >= 2 && cyc <= 6);
        if (idx < 5) drive(bp[idx], 1'b1);
        else in_valid = 1'b0;
        #1;
        if (hold) begin
          check($sformatf("bp_c%0d_s_stable", cyc), s, hs);
          check($sformatf("bp_c%0d_f_stable", cyc), flags, hf);
        end
        if (out_valid && out_ready) begin
          if (got < 5) begin
            check($sformatf("bp%0d_s", got), s, bp[got].s);
            check($sformatf("bp%0d_flags", got), flags, bp[got].f);
          end
          got++;
        end
        if (cyc >= 2 && cyc <= 6) check($sformatf("bp_c%0d_in_ready", cyc), in_ready, 0);
        if (in_valid && in_ready) idx++;
        if (cyc == 6) check("bp_accepted_before_stall", idx, 2);
        hold = out_valid && !out_ready;
        hs   = s;
        hf   = flags;
      end
      out_ready = 1'b1;
      check("bp_all_accepted", idx, 5);
      check("bp_all_emitted", got, 5);
    end

    // Reset with two beats in flight: nothing stale emerges and Cf is cleared.
    do_reset();
    @(negedge clk);
    drive(vecs[0], 1'b1);              // ADD FF+01 sets C=1
    @(negedge clk);
    drive('{OP_ADD, 8'h01, 8'h01, 8'h02, 4'b0000}, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_flags", flags, 0);
    rst_n = 1'b1;
    #1;
    check("mid_rst_release_in_ready", in_ready, 1);
    begin
      int stale = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (out_valid) stale++;
      end
      check("mid_rst_no_stale", stale, 0);
    end
    @(negedge clk);
    drive('{OP_ADC, 8'h01, 8'h01, 8'h02, 4'b0000}, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_adc_valid", out_valid, 1);
    check("mid_rst_adc_s", s, 8'h02);
    check("mid_rst_adc_flags", flags, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be even and >= 4.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 Port rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port in_valid  input  1  operand beat present.
REQ-005 Port in_ready  output  1  block accepts beat this cycle.
REQ-006 Port a  input  WIDTH  operand A.
REQ-007 Port b  input  WIDTH  operand B.
REQ-008 Port op  input  2  00 ADD, 01 SUB, 10 ADC (add with carry flag), 11 SBB (subtract with borrow from carry flag).
REQ-009 Port out_valid  output  1  result present.
REQ-010 Port out_ready  input  1  consumer accepts result.
REQ-011 Port s  output  WIDTH  result.
REQ-012 Port flags  output  4  {N, Z, V, C} for the result on s.

Function
REQ-013 Transfer on a port SHALL occur only in cycles where valid and ready are both high.
REQ-014 Two register stages: S1 holds a, b, op; S2 holds s, flags. Accepted beat SHALL appear on out_valid exactly 2 cycles later when out_ready stays high.
REQ-015 adv2 = !out_valid | out_ready; S1 SHALL move to S2 when S1 valid and adv2; in_ready = !S1_valid | adv2 (combinational, no in_valid dependence).
REQ-016 With out_ready held low, block SHALL hold 2 results max (S1 + S2) and SHALL not drop, duplicate or reorder beats; s/flags SHALL stay stable while out_valid & !out_ready.
REQ-017 Sum computed in S1->S2 transfer: ADD a+b+0; SUB a+~b+1; ADC a+b+Cf; SBB a+~b+Cf; Cf = internal carry register.
REQ-018 C = carry-out of MSB (for SUB/SBB, C=1 means no borrow); V = carry into MSB XOR carry out of MSB; Z = (s==0); N = s[WIDTH-1].
REQ-019 Cf SHALL update with the C of each result written into S2, so an ADC/SBB uses the C of the immediately preceding op in acceptance order, including back-to-back beats.
REQ-020 Sum width rule: result truncated to WIDTH bits; wrap-around is modulo 2^WIDTH.
REQ-021 Simultaneous S2 drain and S1 refill and new input accept SHALL all occur in one cycle without bubble (full throughput 1 beat/cycle).

Reset
REQ-022 On rst_n low at a clock edge: S1_valid=0, out_valid=0, s=0, flags=0, Cf=0.
REQ-023 in_ready SHALL be 0 while rst_n is low; beats in flight at reset SHALL be discarded and never emitted.
REQ-024 First cycle after rst_n rises, in_ready SHALL be 1.

Structure
REQ-025 Shared package addsub_pkg SHALL hold op encodings (OP_ADD, OP_SUB, OP_ADC, OP_SBB) and flag bit indices (FLG_C=0, FLG_V=1, FLG_Z=2, FLG_N=3).
REQ-026 Sum logic SHALL be sub-module cla_nbit (parameter WIDTH, built from 2-bit carry-lookahead groups, rippling group carry), exposing sum, carry-out and carry-into-MSB.
REQ-027 No combinational path SHALL exist from a/b/op to s/flags.

Verification (WIDTH=8, out_ready=1 unless stated)
REQ-028 ADD 0xFF+0x01 -> s=0x00, C=1 V=0 Z=1 N=0, out_valid 2 cycles after accept.
REQ-029 ADD 0x7F+0x01 -> s=0x80, C=0 V=1 Z=0 N=1; SUB 0x80-0x01 -> s=0x7F, C=1 V=1.
REQ-030 SUB 0x01-0x02 -> s=0xFF, C=0 N=1; next beat SBB 0x00-0x00 -> s=0xFF, C=0 (borrow propagated back-to-back).
REQ-031 ADD 0xFF+0x01 then ADC 0x00+0x00 -> second s=0x01, C=0 (16-bit chain 0x00FF+0x0001=0x0100).
REQ-032 Stream 5 beats with out_ready low for cycles 2-6 -> exactly 2 accepted before in_ready drops, all 5 results emitted in order, held values stable.
REQ-033 Assert rst_n low for 1 cycle with 2 beats in flight -> out_valid=0, flags=0 next cycle, no stale result emitted; following ADC 0x01+0x01 -> s=0x02 (Cf cleared).
